// File: rtl/simon_core_param.sv
// simon_core_param: iterative SIMON block cipher with an on-chip round-key store, one round per clock.
// Define SIMON_DECRYPT_EN to build the decrypt datapath; otherwise enc_dec is ignored and every block encrypts.
module simon_core_param #(
  parameter int N  = 24,
  parameter int M  = 4,
  parameter int T  = 36,
  parameter int ZI = 1,
  parameter int Cb = 7
) (
  input  logic                clk,
  input  logic                nR,
  input  logic                newKey,
  input  logic [M-1:0][N-1:0] KEY,
  output logic                loadKey,
  output logic                doneKey,
  input  logic                newData,
  input  logic                enc_dec,
  input  logic [1:0][N-1:0]   blockIN,
  output logic                loadData,
  input  logic                readData,
  output logic                doneData,
  output logic [1:0][N-1:0]   outData,
  output logic [2:0]          mode
);

  localparam int AW = $clog2(T);

  // z sequences stored with element 0 in bit 0
  localparam logic [61:0] Z0 = 62'b0110011100_0011010100_1000101111_1011001110_0001101010_010001011111;
  localparam logic [61:0] Z1 = 62'b0101101000_0110010011_1110111000_1010110100_0011001001_111101110001;
  localparam logic [61:0] Z2 = 62'b1100110110_1001111110_0010000101_0001100100_1011000000_111011110101;
  localparam logic [61:0] Z3 = 62'b1111000010_1100111001_0100010010_0000011110_1001100011_010111011011;
  localparam logic [61:0] Z4 = 62'b1111011100_1001010011_0000111010_0000010001_1011010110_011110001011;
  localparam logic [61:0] ZSEQ = (ZI == 0) ? Z0 : (ZI == 1) ? Z1 : (ZI == 2) ? Z2 :
                                 (ZI == 3) ? Z3 : Z4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KEXP  = 3'd1,
    READY = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_e;

  function automatic logic [N-1:0] fRound(input logic [N-1:0] v);
    return ({v[N-2:0], v[N-1]} & {v[N-9:0], v[N-1:N-8]}) ^ {v[N-3:0], v[N-1:N-2]};
  endfunction

  state_e           state_q, state_d;
  logic [Cb-1:0]    cnt_q, cnt_d;
  logic [N-1:0]     x_q, x_d, y_q, y_d;
  logic [1:0][N-1:0] out_q, out_d;
  logic [N-1:0]     rk_q [T];

  logic             keyCap;
  logic [AW-1:0]    wrIdx, prev1, prev3, prevM, rIdx;
  logic [Cb-1:0]    zOff;
  logic [5:0]       zSel;
  logic             zBit;
  logic [N-1:0]     t0, t1, t2, rkNew;
  logic [N-1:0]     rkRound, nextX, nextY;
  logic             lastStep;

  assign keyCap   = newKey && ((state_q == IDLE) || (state_q == READY));
  assign wrIdx    = cnt_q[AW-1:0];
  assign prev1    = wrIdx - AW'(1);
  assign prev3    = wrIdx - AW'(3);
  assign prevM    = wrIdx - AW'(M);
  assign zOff     = cnt_q - Cb'(M);
  assign zSel     = (zOff >= Cb'(62)) ? 6'(zOff - Cb'(62)) : 6'(zOff);
  assign zBit     = ZSEQ[zSel];
  assign lastStep = (cnt_q == Cb'(T - 1));

  // Key expansion: one new schedule word per cycle from the words already stored
  always_comb begin
    t0    = {rk_q[prev1][2:0], rk_q[prev1][N-1:3]};
    t1    = (M == 4) ? (t0 ^ rk_q[prev3]) : t0;
    t2    = t1 ^ {t1[0], t1[N-1:1]};
    rkNew = ~rk_q[prevM] ^ t2 ^ {{(N-1){1'b0}}, zBit} ^ {{(N-2){1'b0}}, 2'b11};
  end

  // The round store is never reset; doneKey low marks its contents invalid
  always_ff @(posedge clk) begin
    if (keyCap) begin
      for (int k = 0; k < M; k++) rk_q[k] <= KEY[k];
    end else if (state_q == KEXP) begin
      rk_q[wrIdx] <= rkNew;
    end
  end

`ifdef SIMON_DECRYPT_EN
  logic dir_q, dir_d;
  logic [N-1:0] encX, decY;

  assign rIdx    = dir_q ? wrIdx : (AW'(T - 1) - wrIdx);
  assign rkRound = rk_q[rIdx];
  assign encX    = y_q ^ fRound(x_q) ^ rkRound;
  assign decY    = x_q ^ fRound(y_q) ^ rkRound;
  assign nextX   = dir_q ? encX : y_q;
  assign nextY   = dir_q ? x_q  : decY;
`else
  logic unusedEncDec;

  assign unusedEncDec = enc_dec;
  assign rIdx    = wrIdx;
  assign rkRound = rk_q[rIdx];
  assign nextX   = y_q ^ fRound(x_q) ^ rkRound;
  assign nextY   = x_q;
`endif

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      out_q   <= '0;
`ifdef SIMON_DECRYPT_EN
      dir_q   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      out_q   <= out_d;
`ifdef SIMON_DECRYPT_EN
      dir_q   <= dir_d;
`endif
    end
  end

  // Re-key has priority over a block offered in the same READY cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    out_d   = out_q;
`ifdef SIMON_DECRYPT_EN
    dir_d   = dir_q;
`endif
    case (state_q)
      IDLE: begin
        if (newKey) begin
          state_d = KEXP;
          cnt_d   = Cb'(M);
        end
      end
      KEXP: begin
        cnt_d = cnt_q + Cb'(1);
        if (lastStep) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      READY: begin
        if (newKey) begin
          state_d = KEXP;
          cnt_d   = Cb'(M);
        end else if (newData) begin
          state_d = RUN;
          cnt_d   = '0;
          x_d     = blockIN[1];
          y_d     = blockIN[0];
`ifdef SIMON_DECRYPT_EN
          dir_d   = enc_dec;
`endif
        end
      end
      RUN: begin
        x_d   = nextX;
        y_d   = nextY;
        cnt_d = cnt_q + Cb'(1);
        if (lastStep) begin
          state_d = DONE;
          cnt_d   = '0;
          out_d   = {nextX, nextY};
        end
      end
      DONE: begin
        if (readData) state_d = READY;
      end
      default: state_d = IDLE;
    endcase
  end

  assign loadKey  = (state_q == IDLE) || (state_q == READY);
  assign loadData = (state_q == READY);
  assign doneKey  = (state_q == READY) || (state_q == RUN) || (state_q == DONE);
  assign doneData = (state_q == DONE);
  assign outData  = out_q;
  assign mode     = state_q;

endmodule

// File: tb/tb_simon_core_param.sv
// Scoreboard bench for simon_core_param: SIMON48/96 and SIMON32/64 vectors, handshake corners and reset.
module tb_simon_core_param;

  localparam logic [95:0] KEY48 = {24'h1a1918, 24'h121110, 24'h0a0908, 24'h020100};
  localparam logic [47:0] PT48  = 48'h726963_20646e;
  localparam logic [47:0] CT48  = 48'h6e06a5_acf156;
  localparam logic [63:0] KEY32 = {16'h1918, 16'h1110, 16'h0908, 16'h0100};
  localparam logic [31:0] PT32  = 32'h6565_6877;
  localparam logic [31:0] CT32  = 32'hc69b_e9bb;

  logic clk = 1'b0;
  logic nR  = 1'b0;
  always #5 clk = ~clk;

  logic              newKey48 = 1'b0, newData48 = 1'b0, enc48 = 1'b1, readData48 = 1'b0;
  logic [3:0][23:0]  key48 = '0;
  logic [1:0][23:0]  blk48 = '0;
  logic              loadKey48, doneKey48, loadData48, doneData48;
  logic [1:0][23:0]  out48;
  logic [2:0]        mode48;

  logic              newKey32 = 1'b0, newData32 = 1'b0, enc32 = 1'b1, readData32 = 1'b0;
  logic [3:0][15:0]  key32 = '0;
  logic [1:0][15:0]  blk32 = '0;
  logic              loadKey32, doneKey32, loadData32, doneData32;
  logic [1:0][15:0]  out32;
  logic [2:0]        mode32;

  int vecCount = 0;
  int errCount = 0;
  logic [47:0] q48 [$];
  logic [31:0] q32 [$];

  simon_core_param dut48 (
    .clk(clk), .nR(nR), .newKey(newKey48), .KEY(key48), .loadKey(loadKey48),
    .doneKey(doneKey48), .newData(newData48), .enc_dec(enc48), .blockIN(blk48),
    .loadData(loadData48), .readData(readData48), .doneData(doneData48),
    .outData(out48), .mode(mode48)
  );

  simon_core_param #(.N(16), .M(4), .T(32), .ZI(0), .Cb(6)) dut32 (
    .clk(clk), .nR(nR), .newKey(newKey32), .KEY(key32), .loadKey(loadKey32),
    .doneKey(doneKey32), .newData(newData32), .enc_dec(enc32), .blockIN(blk32),
    .loadData(loadData32), .readData(readData32), .doneData(doneData32),
    .outData(out32), .mode(mode32)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] rol24(input logic [23:0] v, input int s);
    return (v << s) | (v >> (24 - s));
  endfunction

  function automatic logic [23:0] ror24(input logic [23:0] v, input int s);
    return (v >> s) | (v << (24 - s));
  endfunction

  // Software SIMON48/96 encryption, used where no published vector exists
  function automatic logic [47:0] refEnc48(input logic [95:0] key, input logic [47:0] blk);
    logic [23:0] rk [36];
    logic [23:0] x, y, t;
    logic [61:0] z;
    z = 62'b0101101000_0110010011_1110111000_1010110100_0011001001_111101110001;
    for (int i = 0; i < 4; i++) rk[i] = key[24*i +: 24];
    for (int i = 4; i < 36; i++) begin
      t = ror24(rk[i-1], 3) ^ rk[i-3];
      t = t ^ ror24(t, 1);
      rk[i] = ~rk[i-4] ^ t ^ {23'b0, z[(i-4) % 62]} ^ 24'd3;
    end
    x = blk[47:24];
    y = blk[23:0];
    for (int i = 0; i < 36; i++) begin
      t = x;
      x = y ^ ((rol24(x, 1) & rol24(x, 8)) ^ rol24(x, 2)) ^ rk[i];
      y = t;
    end
    return {x, y};
  endfunction

  // Key load with exact-latency checks and an ignored newData poke mid-expansion
  task automatic applyKey48(input logic [95:0] key);
    @(negedge clk);
    key48    = key;
    newKey48 = 1'b1;
    @(negedge clk);
    newKey48 = 1'b0;
    checkOutput("kexp_entry_mode", 64'(mode48), 64'd1);
    checkOutput("kexp_entry_doneKey", 64'(doneKey48), 64'd0);
    repeat (4) @(negedge clk);
    newData48 = 1'b1;
    blk48     = PT48;
    @(negedge clk);
    newData48 = 1'b0;
    checkOutput("kexp_newData_ignored", {61'd0, mode48}, 64'd1);
    repeat (26) @(negedge clk);
    checkOutput("kexp_e31_doneKey", 64'(doneKey48), 64'd0);
    @(negedge clk);
    checkOutput("kexp_e32_doneKey", 64'(doneKey48), 64'd1);
    checkOutput("kexp_e32_mode", 64'(mode48), 64'd2);
    checkOutput("kexp_e32_loadData", 64'(loadData48), 64'd1);
  endtask

  // Block run with exact-latency checks and an ignored newData poke mid-run
  task automatic applyStimulus(input logic [47:0] blk, input logic ed, input logic [47:0] exp);
    q48.push_back(exp);
    @(negedge clk);
    blk48     = blk;
    enc48     = ed;
    newData48 = 1'b1;
    @(negedge clk);
    newData48 = 1'b0;
    checkOutput("run_entry_mode", 64'(mode48), 64'd3);
    checkOutput("run_entry_loadData", 64'(loadData48), 64'd0);
    repeat (5) @(negedge clk);
    newData48 = 1'b1;
    blk48     = ~blk;
    @(negedge clk);
    newData48 = 1'b0;
    checkOutput("run_newData_ignored", 64'(mode48), 64'd3);
    repeat (29) @(negedge clk);
    checkOutput("run_d35_doneData", 64'(doneData48), 64'd0);
    @(negedge clk);
    checkOutput("run_d36_doneData", 64'(doneData48), 64'd1);
    checkOutput("run_d36_mode", 64'(mode48), 64'd4);
  endtask

  task automatic ack48();
    @(negedge clk);
    readData48 = 1'b1;
    @(negedge clk);
    readData48 = 1'b0;
    checkOutput("ack_mode", 64'(mode48), 64'd2);
    checkOutput("ack_doneData", 64'(doneData48), 64'd0);
  endtask

  // Monitors pop the scoreboard on each rising doneData
  initial begin
    logic prev;
    logic [47:0] exp;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (doneData48 && !prev) begin
        if (q48.size() == 0) begin
          checkOutput("unexpected_done48", 64'(out48), 64'd0 - 64'd1);
        end else begin
          exp = q48.pop_front();
          checkOutput("outData48", 64'(out48), 64'(exp));
        end
      end
      prev = doneData48;
    end
  end

  initial begin
    logic prev;
    logic [31:0] exp;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (doneData32 && !prev) begin
        if (q32.size() == 0) begin
          checkOutput("unexpected_done32", 64'(out32), 64'd0 - 64'd1);
        end else begin
          exp = q32.pop_front();
          checkOutput("outData32", 64'(out32), 64'(exp));
        end
      end
      prev = doneData32;
    end
  end

  initial begin
    int holdErr;
    int waitCnt;
    logic [47:0] decExp;

`ifdef SIMON_DECRYPT_EN
    decExp = PT48;
`else
    decExp = refEnc48(KEY48, CT48);
`endif

    repeat (2) @(negedge clk);
    checkOutput("rst_mode", 64'(mode48), 64'd0);
    checkOutput("rst_loadKey", 64'(loadKey48), 64'd1);
    checkOutput("rst_loadData", 64'(loadData48), 64'd0);
    checkOutput("rst_doneKey", 64'(doneKey48), 64'd0);
    checkOutput("rst_doneData", 64'(doneData48), 64'd0);
    checkOutput("rst_outData", 64'(out48), 64'd0);
    checkOutput("rst_mode32", 64'(mode32), 64'd0);
    nR = 1'b1;

    $display("[TB] SIMON48/96 encrypt and decrypt");
    applyKey48(KEY48);
    applyStimulus(PT48, 1'b1, CT48);
    ack48();
    applyStimulus(CT48, 1'b0, decExp);
    ack48();

    $display("[TB] DONE hold for 100 cycles with ignored newKey");
    applyStimulus(PT48, 1'b1, CT48);
    holdErr  = 0;
    newKey48 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      newKey48 = 1'b0;
      if (doneData48 !== 1'b1 || out48 !== CT48 || mode48 !== 3'd4 || doneKey48 !== 1'b1)
        holdErr++;
    end
    checkOutput("done_hold_stable", 64'(holdErr), 64'd0);
    ack48();

    $display("[TB] newKey and newData together in READY");
    @(negedge clk);
    newKey48  = 1'b1;
    newData48 = 1'b1;
    blk48     = PT48;
    @(negedge clk);
    newKey48  = 1'b0;
    newData48 = 1'b0;
    checkOutput("both_mode", 64'(mode48), 64'd1);
    checkOutput("both_doneKey", 64'(doneKey48), 64'd0);
    repeat (32) @(negedge clk);
    checkOutput("both_block_dropped", 64'(mode48), 64'd2);
    applyStimulus(PT48, 1'b1, CT48);
    ack48();

    $display("[TB] SIMON32/64 encrypt");
    @(negedge clk);
    key32    = KEY32;
    newKey32 = 1'b1;
    @(negedge clk);
    newKey32 = 1'b0;
    waitCnt  = 0;
    while (!doneKey32 && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("k32_latency", 64'(waitCnt), 64'd28);
    q32.push_back(CT32);
    blk32     = PT32;
    newData32 = 1'b1;
    @(negedge clk);
    newData32 = 1'b0;
    waitCnt   = 0;
    while (!doneData32 && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("d32_latency", 64'(waitCnt), 64'd32);
    readData32 = 1'b1;
    @(negedge clk);
    readData32 = 1'b0;
    checkOutput("ack32_mode", 64'(mode32), 64'd2);

    $display("[TB] reset during RUN");
    @(negedge clk);
    blk48     = PT48;
    enc48     = 1'b1;
    newData48 = 1'b1;
    @(negedge clk);
    newData48 = 1'b0;
    repeat (9) @(negedge clk);
    #2 nR = 1'b0;
    #1;
    checkOutput("mrst_mode", 64'(mode48), 64'd0);
    checkOutput("mrst_loadKey", 64'(loadKey48), 64'd1);
    checkOutput("mrst_loadData", 64'(loadData48), 64'd0);
    checkOutput("mrst_doneKey", 64'(doneKey48), 64'd0);
    checkOutput("mrst_doneData", 64'(doneData48), 64'd0);
    checkOutput("mrst_outData", 64'(out48), 64'd0);
    @(negedge clk);
    nR = 1'b1;
    repeat (3) @(negedge clk);
    newData48 = 1'b1;
    @(negedge clk);
    newData48 = 1'b0;
    @(negedge clk);
    checkOutput("mrst_no_data_without_key", 64'(loadData48), 64'd0);
    checkOutput("mrst_still_idle", 64'(mode48), 64'd0);
    applyKey48(KEY48);
    applyStimulus(PT48, 1'b1, CT48);
    ack48();

    repeat (3) @(negedge clk);
    checkOutput("q48_drained", 64'(q48.size()), 64'd0);
    checkOutput("q32_drained", 64'(q32.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule

// File: doc/simon_core_param.md
# simon_core_param

Parametrised, iterative SIMON block cipher core covering every standard block/key size from one RTL source. It expands the key once into an on-chip round-key store, then encrypts or decrypts any number of blocks against that schedule at one round per clock. It sits behind the same load/done/read handshakes as the fixed-size SIMON wrappers and replaces them.

## Interface
- N, 24, word size in bits (16, 24, 32, 48, 64); block = 2N
- M, 4, key words (2, 3, 4); key = M·N
- T, 36, round count (32/36/42/44/52/54/68/69/72 per standard)
- ZI, 1, z-sequence index 0..4 selecting the 62-bit constant
- Cb, 7, round-counter width; must satisfy 2^Cb > T
- clk  in  1  clock, rising edge
- nR  in  1  asynchronous, active-low reset
- newKey  in  1  key-capture strobe
- KEY  in  [M-1:0][N-1:0]  key; KEY[0] = k0
- loadKey  out  1  core accepts newKey
- doneKey  out  1  schedule valid
- newData  in  1  block-capture strobe
- enc_dec  in  1  1 = encrypt, 0 = decrypt; sampled with newData
- blockIN  in  [1:0][N-1:0]  [1] = x (left), [0] = y (right)
- loadData  out  1  core accepts newData
- readData  in  1  host has consumed outData
- doneData  out  1  outData valid
- outData  out  [1:0][N-1:0]  result, same word order
- mode  out  3  FSM state: IDLE=0, KEXP=1, READY=2, RUN=3, DONE=4

## Operation
- Round store: T×N registers. rk[0..M-1] = KEY[0..M-1] on capture.
- Expansion, i = M..T-1, one word per cycle:
  - tmp = ROR3(rk[i-1]); if M==4, tmp ^= rk[i-3]
  - tmp ^= ROR1(tmp)
  - rk[i] = ~rk[i-M] ^ tmp ^ z_ZI[(i-M) mod 62] ^ 3
- f(x) = (ROL1 x & ROL8 x) ^ ROL2 x.
- Encrypt round i = 0..T-1: (x, y) ← (y ^ f(x) ^ rk[i], x).
- Decrypt round j = 0..T-1: (x, y) ← (y, x ^ f(y) ^ rk[T-1-j]).
- FSM:
  - IDLE: newKey → KEXP.
  - KEXP: counter M..T-1 → READY.
  - READY: newKey → KEXP (re-key); else newData → RUN.
  - RUN: T rounds → DONE.
  - DONE: readData → READY.
- Outputs:
  - loadKey = 1 in IDLE and READY.
  - loadData = 1 in READY only.
  - doneKey = 1 in READY/RUN/DONE; cleared on entering KEXP.
  - doneData = 1 in DONE only.
- Ignored inputs (no state change): newKey in KEXP/RUN/DONE; newData outside READY; readData outside DONE.
- newKey and newData together in READY: key wins, block is dropped.
- outData holds its last value until the next DONE.

## Timing
- Reset (async, nR=0): mode=IDLE, loadKey=1, loadData=0, doneKey=0, doneData=0, outData=0, counter=0. The round store need not be cleared; doneKey=0 marks it invalid.
- Reset mid-KEXP or mid-RUN: discards all work; the host must reload the key.
- Key capture at edge E: rk[M..T-1] written on edges E+1..E+T-M; READY/doneKey/loadData valid after edge E+T-M.
- Block capture at edge D: rounds on edges D+1..D+T; DONE/doneData/outData valid after edge D+T.
- readData at edge R: READY after R, so back-to-back throughput is T+2 cycles per block.
- M == T is illegal and does not need to be supported.

## Configuration
- SIMON_DECRYPT_EN defined:
  - Decrypt datapath and reverse key indexing present.
  - enc_dec honoured.
- Not defined:
  - Decrypt logic omitted; enc_dec ignored; every block encrypts.
  - Control and timing are identical.

## Test plan
- SIMON48/96 encrypt (defaults), KEY[3..0] = 1a1918, 121110, 0a0908, 020100; blockIN = {726963, 20646e}, enc_dec=1 → outData = {6e06a5, acf156}, doneKey exactly 32 cycles after the newKey edge, doneData exactly 36 cycles after the newData edge.
- Same key, blockIN = {6e06a5, acf156}, enc_dec=0, with SIMON_DECRYPT_EN → {726963, 20646e}. Without the macro → same result as encrypting that block.
- SIMON32/64 (N=16, M=4, T=32, ZI=0), KEY[3..0] = 1918, 1110, 0908, 0100; block {6565, 6877} → {c69b, e9bb}.
- Handshake edges, each checked for no change in mode or outputs:
  - newData during KEXP and RUN is ignored.
  - readData held low in DONE keeps doneData=1 and outData stable for 100 cycles.
  - newKey+newData in the same READY cycle → KEXP, block dropped.
- nR pulsed low at round 10 of RUN → all outputs at reset values immediately; loadData stays 0 until a new key is loaded; the re-run of the first scenario passes.
